// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_STARVE  = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts cycles of an outstanding memory access and flags when it must be aborted
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int STARVE  = DEF_STARVE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          pipe_stall,
  output logic          bus_err
);

  localparam int SW = $clog2(STARVE + 1);

  state_e        state_q;
  owner_e        owner_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          if_ready_q;
  logic          dm_ready_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          bus_err_q;

  logic dm_pend;
  logic if_starved;
  logic grant_dm;
  logic grant_if;
  logic tmo_expired;

  // Starvation only matters while IF is actually waiting for the port.
  assign dm_pend    = dm_read | dm_write;
  assign if_starved = (starve_q == SW'(STARVE)) && if_req;
  assign grant_dm   = (state_q == ST_IDLE) && dm_pend && !if_starved;
  assign grant_if   = (state_q == ST_IDLE) && !grant_dm && if_req;

  // A DM grant with if_req high implies the counter is below STARVE, so it saturates by construction.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm && if_req) begin
      starve_d = starve_q + SW'(1);
    end
  end

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_dm | grant_if),
    .en     (state_q == ST_BUSY),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_dm) begin
            owner_q     <= OWN_DM;
            mem_addr_q  <= dm_addr;
            mem_we_q    <= dm_write;
            mem_wdata_q <= dm_wdata;
            mem_req_q   <= 1'b1;
            state_q     <= ST_BUSY;
          end else if (grant_if) begin
            owner_q     <= OWN_IF;
            mem_addr_q  <= if_addr;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack || tmo_expired) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (!mem_ack) begin
              bus_err_q <= 1'b1;
            end
            if (owner_q == OWN_DM) begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= mem_ack ? mem_rdata : '0;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        ST_RESP: begin
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_ready   = if_ready_q;
  assign dm_ready   = dm_ready_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign bus_err    = bus_err_q;
  assign pipe_stall = (dm_pend & ~dm_ready_q) | (if_req & ~if_ready_q);

endmodule
